noc_pe_inject_arbiter: RTL and testbench

//  Shares one openNocTop PE injection port (r_valid_pe/r_data_pe/r_ready_pe slice) among N local requesters.

---
 rtl/noc_pe_inject_arbiter.sv | 143 ++++++++++++++
 tb/tb_noc_pe_inject_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/noc_pe_inject_arbiter.sv
// noc_pe_inject_arbiter
// Shares one NoC PE injection port among N local requesters. Arbitration is
// round-robin, and a granted multi-beat packet keeps the port until its last
// beat. The selected beat is packed into a flit as {payload, y, x} and held in
// a single output register that faces the switch.
module noc_pe_inject_arbiter #(
    parameter int N           = 4,
    parameter int data_width  = 256,
    parameter int x_size      = 1,
    parameter int y_size      = 1,
    parameter int total_width = x_size + y_size + data_width,
    localparam int IDX_W      = (N > 1) ? $clog2(N) : 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [N-1:0]               req_valid,
    input  logic [N-1:0]               req_last,
    input  logic [N*x_size-1:0]        req_x,
    input  logic [N*y_size-1:0]        req_y,
    input  logic [N*data_width-1:0]    req_data,
    output logic [N-1:0]               req_ready,
    output logic                       o_valid_pe,
    output logic [total_width-1:0]     o_data_pe,
    input  logic                       i_ready_pe,
    output logic [IDX_W-1:0]           grant_id,
    output logic                       locked
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]       owner, owner_nxt;
    logic [IDX_W-1:0]       grant_nxt;
    logic                   locked_nxt;

    logic [IDX_W-1:0]       win_idx;
    logic                   win_found;
    logic                   can_load;
    logic                   accept;
    logic                   win_last;
    logic [IDX_W-1:0]       win_plus1;
    logic [total_width-1:0] flit_nxt;

    // Pick the winner: the lock owner while a packet is in flight, otherwise
    // the first valid requester searching upward from the round-robin pointer.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        if (state == LOCK) begin
            win_idx   = owner;
            win_found = req_valid[owner];
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!win_found && req_valid[(int'(rr_ptr) + k) % N]) begin
                    win_found = 1'b1;
                    win_idx   = IDX_W'((int'(rr_ptr) + k) % N);
                end
            end
        end
    end

    // Handshake towards the requesters and the packed flit for the winner.
    // req_ready is forced low while reset is held, because the cleared output
    // register would otherwise look ready to load.
    always_comb begin
        can_load  = !o_valid_pe || i_ready_pe;
        accept    = can_load && win_found && rstn;
        win_last  = req_last[win_idx];
        win_plus1 = (int'(win_idx) == N - 1) ? '0 : win_idx + 1'b1;
        flit_nxt  = {req_data[int'(win_idx)*data_width +: data_width],
                     req_y[int'(win_idx)*y_size +: y_size],
                     req_x[int'(win_idx)*x_size +: x_size]};
        req_ready = '0;
        if (accept) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    // Next-state logic for the packet-lock FSM, the round-robin pointer and
    // the grant/lock status outputs.
    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        owner_nxt  = owner;
        grant_nxt  = grant_id;
        locked_nxt = locked;
        case (state)
            IDLE: begin
                if (accept) begin
                    grant_nxt = win_idx;
                    if (win_last) begin
                        rr_ptr_nxt = win_plus1;
                    end else begin
                        state_nxt  = LOCK;
                        owner_nxt  = win_idx;
                        locked_nxt = 1'b1;
                    end
                end
            end
            LOCK: begin
                if (accept && win_last) begin
                    state_nxt  = IDLE;
                    locked_nxt = 1'b0;
                    rr_ptr_nxt = win_plus1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            grant_id <= '0;
            locked   <= 1'b0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            owner    <= owner_nxt;
            grant_id <= grant_nxt;
            locked   <= locked_nxt;
        end
    end

    // Output flit register: loads an accepted beat, holds it under
    // backpressure and goes idle once the switch has consumed it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_valid_pe <= 1'b0;
            o_data_pe  <= '0;
        end else if (accept) begin
            o_valid_pe <= 1'b1;
            o_data_pe  <= flit_nxt;
        end else if (i_ready_pe) begin
            o_valid_pe <= 1'b0;
        end
    end

endmodule

// File: tb/tb_noc_pe_inject_arbiter.sv
// tb_noc_pe_inject_arbiter
// Directed bench for the PE injection arbiter: reset, round-robin order,
// packet lock, flit packing, backpressure, wrap-around and reset mid-packet.
module tb_noc_pe_inject_arbiter;

    localparam int N  = 4;
    localparam int DW = 256;
    localparam int TW = DW + 2;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_x;
    logic [N-1:0]    req_y;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            o_valid_pe;
    logic [TW-1:0]   o_data_pe;
    logic            i_ready_pe;
    logic [1:0]      grant_id;
    logic            locked;

    int total_count = 0;
    int bad_count   = 0;

    noc_pe_inject_arbiter #(
        .N(N), .data_width(DW), .x_size(1), .y_size(1)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_last(req_last),
        .req_x(req_x), .req_y(req_y), .req_data(req_data),
        .req_ready(req_ready),
        .o_valid_pe(o_valid_pe), .o_data_pe(o_data_pe), .i_ready_pe(i_ready_pe),
        .grant_id(grant_id), .locked(locked)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total_count++;
        if (got !== exp) begin
            bad_count++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drives the per-cycle handshake inputs.
    task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] l, input logic rdy);
        req_valid  = v;
        req_last   = l;
        i_ready_pe = rdy;
    endtask

    // Default destinations/payloads: x = i[0], y = i[1], payload = 0x10+i.
    task automatic setDefaultPayloads();
        req_x = 4'b1010;
        req_y = 4'b1100;
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = DW'(32'h10 + i);
        end
    endtask

    // Expected flit for requester i, built from the values the bench drives.
    function automatic logic [TW-1:0] expFlit(input int i);
        return {req_data[i*DW +: DW], req_y[i], req_x[i]};
    endfunction

    // Checks req_ready mid-cycle, then advances to just after the next rising edge.
    task automatic stepCycle(input string tag, input logic [N-1:0] exp_ready);
        @(negedge clk);
        checkOutput({tag, "_ready"}, 512'(req_ready), 512'(exp_ready));
        @(posedge clk);
        #1;
    endtask

    // Checks the registered outputs; the flit is only compared when valid.
    task automatic checkRegs(input string tag, input logic exp_valid, input logic [TW-1:0] exp_data,
                             input logic [1:0] exp_grant, input logic exp_locked);
        checkOutput({tag, "_valid"}, 512'(o_valid_pe), 512'(exp_valid));
        if (exp_valid) begin
            checkOutput({tag, "_data"}, 512'(o_data_pe), 512'(exp_data));
        end
        checkOutput({tag, "_grant"}, 512'(grant_id), 512'(exp_grant));
        checkOutput({tag, "_locked"}, 512'(locked), 512'(exp_locked));
    endtask

    initial begin
        rstn = 1'b1;
        setDefaultPayloads();
        applyStimulus(4'b1111, 4'b1111, 1'b1);

        // T1: reset with every requester valid
        #1 rstn = 1'b0;
        #1;
        checkOutput("t1_valid", 512'(o_valid_pe), 512'(0));
        checkOutput("t1_ready", 512'(req_ready), 512'(0));
        checkOutput("t1_locked", 512'(locked), 512'(0));
        checkOutput("t1_grant", 512'(grant_id), 512'(0));
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t1_hold_valid", 512'(o_valid_pe), 512'(0));
        checkOutput("t1_hold_ready", 512'(req_ready), 512'(0));
        rstn = 1'b1;

        // T2: all single-beat -> grants 0,1,2,3,0 back to back (includes wrap)
        for (int k = 0; k < 5; k++) begin
            stepCycle($sformatf("t2_%0d", k), 4'(1 << (k % 4)));
            checkRegs($sformatf("t2_%0d", k), 1'b1, expFlit(k % 4), 2'(k % 4), 1'b0);
        end

        // Nothing valid: output goes idle after the last flit is consumed
        applyStimulus(4'b0000, 4'b1111, 1'b1);
        stepCycle("idle", 4'b0000);
        checkRegs("idle", 1'b0, '0, 2'd0, 1'b0);

        // T3: rr_ptr=1, req1 sends 3 beats while req0/req2 wait
        applyStimulus(4'b0111, 4'b0101, 1'b1);
        stepCycle("t3_b1", 4'b0010);
        checkRegs("t3_b1", 1'b1, expFlit(1), 2'd1, 1'b1);
        stepCycle("t3_b2", 4'b0010);
        checkRegs("t3_b2", 1'b1, expFlit(1), 2'd1, 1'b1);
        applyStimulus(4'b0111, 4'b0111, 1'b1);
        stepCycle("t3_b3", 4'b0010);
        checkRegs("t3_b3", 1'b1, expFlit(1), 2'd1, 1'b0);
        applyStimulus(4'b0101, 4'b0101, 1'b1);
        stepCycle("t3_next", 4'b0100);
        checkRegs("t3_next", 1'b1, expFlit(2), 2'd2, 1'b0);

        // T4: flit packing, rr_ptr=3 but only req2 valid
        req_data[2*DW +: DW] = DW'(8'hA5);
        req_x[2] = 1'b1;
        req_y[2] = 1'b0;
        applyStimulus(4'b0100, 4'b0100, 1'b1);
        stepCycle("t4", 4'b0100);
        checkRegs("t4", 1'b1, {256'hA5, 1'b0, 1'b1}, 2'd2, 1'b0);

        // T5: backpressure for 5 cycles holds the flit and blocks everyone
        setDefaultPayloads();
        applyStimulus(4'b1111, 4'b1111, 1'b0);
        for (int k = 0; k < 5; k++) begin
            stepCycle($sformatf("t5_hold%0d", k), 4'b0000);
            checkRegs($sformatf("t5_hold%0d", k), 1'b1, TW'(10'h295), 2'd2, 1'b0);
        end
        applyStimulus(4'b1111, 4'b1111, 1'b1);
        stepCycle("t5_release", 4'b1000);
        checkRegs("t5_release", 1'b1, expFlit(3), 2'd3, 1'b0);
        stepCycle("t5_wrap", 4'b0001);
        checkRegs("t5_wrap", 1'b1, expFlit(0), 2'd0, 1'b0);

        // T6: lock on req1, owner gap, then async reset mid-packet
        applyStimulus(4'b1111, 4'b1101, 1'b1);
        stepCycle("t6_b1", 4'b0010);
        checkRegs("t6_b1", 1'b1, expFlit(1), 2'd1, 1'b1);
        applyStimulus(4'b1101, 4'b1101, 1'b1);
        stepCycle("t6_gap", 4'b0000);
        checkRegs("t6_gap", 1'b0, '0, 2'd1, 1'b1);
        applyStimulus(4'b1111, 4'b1101, 1'b1);
        stepCycle("t6_b2", 4'b0010);
        checkRegs("t6_b2", 1'b1, expFlit(1), 2'd1, 1'b1);
        #2 rstn = 1'b0;
        #1;
        checkOutput("t6_rst_valid", 512'(o_valid_pe), 512'(0));
        checkOutput("t6_rst_locked", 512'(locked), 512'(0));
        checkOutput("t6_rst_ready", 512'(req_ready), 512'(0));
        @(posedge clk);
        #1 rstn = 1'b1;
        applyStimulus(4'b1111, 4'b1111, 1'b1);
        stepCycle("t6_after", 4'b0001);
        checkRegs("t6_after", 1'b1, expFlit(0), 2'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule
